// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory load/store controller.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_DONE
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Major opcodes the decoder uses to raise mem_read/mem_write.
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/data_mem_ctrl_lsu_align.sv
// Combinational byte-lane logic: store be/wdata generation, access legality
// check, and load lane extraction with sign/zero extension.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic        is_store_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_c_o,
    output logic [31:0] wdata_c_o,
    output logic        illegal_c_o,
    output logic [31:0] ldata_c_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Request side: lanes, replicated store data, legality.
    always_comb begin
        be_c_o      = 4'b1111;
        wdata_c_o   = wdata_i;
        illegal_c_o = 1'b0;
        case (funct3_i)
            F3_B: begin
                be_c_o    = 4'(4'b0001 << addr_lo_i);
                wdata_c_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                be_c_o      = 4'(4'b0011 << addr_lo_i);
                wdata_c_o   = {2{wdata_i[15:0]}};
                illegal_c_o = addr_lo_i[0];
            end
            F3_W: begin
                illegal_c_o = |addr_lo_i;
            end
            F3_BU: begin
                be_c_o      = 4'(4'b0001 << addr_lo_i);
                illegal_c_o = is_store_i;
            end
            F3_HU: begin
                be_c_o      = 4'(4'b0011 << addr_lo_i);
                illegal_c_o = is_store_i | addr_lo_i[0];
            end
            default: begin
                illegal_c_o = 1'b1;
            end
        endcase
    end

    // Response side: pick the lane from the latched offset and extend.
    always_comb begin
        case (ld_addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_funct3_i)
            F3_B:    ldata_c_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ldata_c_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ldata_c_o = {24'd0, byte_sel};
            F3_HU:   ldata_c_o = {16'd0, half_sel};
            default: ldata_c_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: turns decoder memory strobes into a req/gnt/rvalid
// transaction and returns a single-cycle ack with error and load data.
module data_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        mem_ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic              illegal_c;
    logic [31:0]       ldata_c;

    lsu_align u_align (
        .funct3_i     (funct3_i),
        .addr_lo_i    (addr_i[1:0]),
        .wdata_i      (wdata_i),
        .is_store_i   (mem_write_i),
        .ld_funct3_i  (f3_q),
        .ld_addr_lo_i (lo_q),
        .rdata_i      (dmem_rdata_i),
        .be_c_o       (be_c),
        .wdata_c_o    (wdata_c),
        .illegal_c_o  (illegal_c),
        .ldata_c_o    (ldata_c)
    );

    // Outputs are computed for the next state so they are registered with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (mem_read_i || mem_write_i) begin
                    if ((mem_read_i && mem_write_i) || illegal_c) begin
                        state_d = ST_DONE;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        we_d    = mem_write_i;
                        addr_d  = {addr_i[31:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        f3_d    = funct3_i;
                        lo_d    = addr_i[1:0];
                    end
                end
            end
            ST_REQ: begin
                // Timeout wins over a grant that arrives after req was dropped.
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end else if (dmem_gnt_i) begin
                    state_d = ST_WAIT_RSP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    req_d = (cnt_d != CNT_MAX);
                end
            end
            ST_WAIT_RSP: begin
                if (dmem_rvalid_i) begin
                    state_d = ST_DONE;
                    ack_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = ldata_c;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign mem_ack_o    = ack_q;
    assign err_o        = err_q;
    assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: per-cycle comparison against a
// transaction-level model, directed scenarios and randomized traffic.
module tb_data_mem_ctrl;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        mem_ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    data_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .mem_ack_o(mem_ack_o), .rdata_o(rdata_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_illegal(input bit rd, input bit wr, input logic [2:0] f3,
                                         input logic [31:0] a);
        int n;
        n = nbytes(f3);
        if (rd && wr) return 1'b1;
        if (n == 0) return 1'b1;
        if (wr && f3[2]) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return 4'(((32'd1 << n) - 32'd1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [31:0] a);
        logic [31:0] v, mask;
        int bits;
        bits = 8 * nbytes(f3);
        v = w >> (8 * (a % 4));
        if (bits < 32) begin
            mask = (32'd1 << bits) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Current transaction as the model sees it.
    bit          active = 1'b0;
    bit          chk_en = 1'b0;
    int          cyc;
    bit          m_wr, m_ill, m_to;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wd;
    int          m_ack_cyc, m_req_last;
    logic [31:0] rd_hold = 32'd0;
    logic [31:0] rd_new  = 32'd0;

    int          req_cnt, ack_at, ack_cnt = 0;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        cap_we, cap_err;

    // Single compare process: every cycle, DUT outputs versus the model.
    always @(negedge clk_i) begin : cmp
        bit er;
        if (chk_en) begin
            if (active) begin
                er = !m_ill && cyc >= 1 && cyc <= m_req_last;
                if (cyc == 0) begin
                    req_cnt = 0;
                    ack_at  = -1;
                end
                chk("req", dmem_req_o, er);
                chk("ack", mem_ack_o, cyc == m_ack_cyc);
                chk("rdata", rdata_o, (cyc >= m_ack_cyc) ? rd_new : rd_hold);
                if (er) begin
                    chk("addr", dmem_addr_o, m_addr & 32'hFFFF_FFFC);
                    chk("be", dmem_be_o, model_be(m_f3, m_addr));
                    chk("wdata", dmem_wdata_o, m_wr ? model_wdata(m_f3, m_wd) : dmem_wdata_o);
                    chk("we", dmem_we_o, m_wr);
                end
                if (cyc == m_ack_cyc) chk("err", err_o, m_ill || m_to);
                if (dmem_req_o) begin
                    req_cnt++;
                    cap_be    = dmem_be_o;
                    cap_wdata = dmem_wdata_o;
                    cap_we    = dmem_we_o;
                end
                if (mem_ack_o) begin
                    ack_at  = cyc;
                    ack_cnt++;
                    cap_err = err_o;
                end
            end else begin
                chk("idle_req", dmem_req_o, 1'b0);
                chk("idle_ack", mem_ack_o, 1'b0);
                chk("idle_rdata", rdata_o, rd_hold);
            end
        end
    end

    // Drives one decoder instruction plus the memory-side responses.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                           input int gd, input int rdly, input bit noise);
        int nl;
        @(posedge clk_i); #1;
        m_wr = wr; m_f3 = f3; m_addr = a; m_wd = wd;
        m_ill = model_illegal(rd, wr, f3, a);
        m_to  = !m_ill && gd >= TO;
        m_ack_cyc  = m_ill ? 1 : (m_to ? TO + 2 : gd + rdly + 3);
        m_req_last = m_to ? TO : 1 + gd;
        rd_new = (!m_ill && !m_to && rd) ? model_load(word, f3, a) : rd_hold;
        nl = m_ill ? 1 : (m_to ? m_ack_cyc : 1 + gd);
        for (int c = 0; c <= m_ack_cyc; c++) begin
            if (c > 0) begin
                @(posedge clk_i); #1;
            end
            cyc = c;
            active = 1'b1;
            if (c == 0) begin
                mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
            end else if (noise) begin
                funct3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
            end
            dmem_gnt_i = (!m_ill && !m_to && c == 1 + gd) ||
                         (noise && c == 0 && $urandom_range(0, 1) == 1);
            dmem_rvalid_i = (!m_ill && !m_to && c == gd + 2 + rdly) ||
                            (noise && c <= nl && $urandom_range(0, 1) == 1);
            dmem_rdata_i = (c == gd + 2 + rdly) ? word : $urandom;
        end
        @(negedge clk_i); #1;
        rd_hold = rd_new;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
            active = 1'b0;
            mem_read_i = 1'b0; mem_write_i = 1'b0;
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        end
    endtask

    // Asynchronous reset pulse while REQ (in_wait=0) or WAIT_RSP (in_wait=1).
    task automatic reset_mid(input bit in_wait);
        chk_en = 1'b0;
        @(posedge clk_i); #1;
        active = 1'b0;
        mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010;
        addr_i = 32'h0000_0300; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        @(posedge clk_i); #1;
        dmem_gnt_i = in_wait;
        if (in_wait) begin
            @(posedge clk_i); #1;
            dmem_gnt_i = 1'b0;
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_req_async", dmem_req_o, 1'b0);
        chk("rst_ack_async", mem_ack_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'd0);
        mem_read_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            chk("late_rvalid_ack", mem_ack_o, 1'b0);
            chk("late_rvalid_req", dmem_req_o, 1'b0);
        end
        rd_hold = 32'd0;
        chk_en = 1'b1;
    endtask

    initial begin
        int acks_before;
        bit rd, wr;
        int kind;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
        legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

        rst_ni = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'd0; wdata_i = 32'd0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
        #3;
        chk("reset_req", dmem_req_o, 1'b0);
        chk("reset_we", dmem_we_o, 1'b0);
        chk("reset_ack", mem_ack_o, 1'b0);
        chk("reset_err", err_o, 1'b0);
        chk("reset_addr", dmem_addr_o, 32'd0);
        chk("reset_be", dmem_be_o, 4'd0);
        chk("reset_wdata", dmem_wdata_o, 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // LW 0x100, immediate gnt/rvalid.
        run_txn(1, 0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0, 0);
        chk("lw_ack_cycle", ack_at, 3);
        chk("lw_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("lw_err", cap_err, 1'b0);
        chk("lw_be", cap_be, 4'b1111);

        // LB / LBU at 0x103.
        run_txn(1, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0, 0);
        chk("lb_be", cap_be, 4'b1000);
        chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
        run_txn(1, 0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0, 0);
        chk("lbu_rdata", rdata_o, 32'h0000_0080);

        // SH at 0x202.
        run_txn(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 0);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_we", cap_we, 1'b1);
        chk("sh_rdata_kept", rdata_o, 32'h0000_0080);

        // Misaligned LW and both strobes.
        run_txn(1, 0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 0, 0, 0);
        chk("mis_ack_cycle", ack_at, 1);
        chk("mis_err", cap_err, 1'b1);
        chk("mis_no_req", req_cnt, 0);
        run_txn(1, 1, 3'b010, 32'h0000_0100, 32'd0, 32'd0, 0, 0, 0);
        chk("both_ack_cycle", ack_at, 1);
        chk("both_err", cap_err, 1'b1);
        chk("both_no_req", req_cnt, 0);

        // Grant withheld, then delayed grant + delayed response.
        run_txn(1, 0, 3'b010, 32'h0000_0400, 32'd0, 32'd0, 20, 0, 0);
        chk("to_req_cycles", req_cnt, 4);
        chk("to_ack_cycle", ack_at, 6);
        chk("to_err", cap_err, 1'b1);
        run_txn(1, 0, 3'b010, 32'h0000_0404, 32'd0, 32'h0BAD_CAFE, 3, 2, 0);
        chk("dly_ack_cycle", ack_at, 8);
        chk("dly_err", cap_err, 1'b0);
        chk("dly_rdata", rdata_o, 32'h0BAD_CAFE);

        // Reset mid-transaction.
        idle(1);
        reset_mid(0);
        reset_mid(1);

        // Back-to-back SW then LW.
        acks_before = ack_cnt;
        run_txn(0, 1, 3'b010, 32'h0000_0500, 32'h1111_2222, 32'd0, 0, 0, 0);
        run_txn(1, 0, 3'b010, 32'h0000_0500, 32'd0, 32'h1111_2222, 0, 0, 0);
        chk("b2b_ack_count", ack_cnt - acks_before, 2);
        chk("b2b_rdata", rdata_o, 32'h1111_2222);

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 9);
            rd = (kind < 5) || (kind == 9);
            wr = (kind >= 5);
            f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_txn(rd, wr, f3, a, $urandom, $urandom,
                    $urandom_range(0, 5), $urandom_range(0, 3), 1);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
